stall_recovery_ctrl: RTL and testbench
======================================

Name: stall_recovery_ctrl

Overview:
Sits directly downstream of the sticky stall flag register and drives that register's clear input. When the sticky flag is raised, the block:
- waits for the MII datapath to drain,
- pulses a flush to the FIFOs,
- issues a single-cycle clear back to the flag register,
- holds off re-arming for a guard interval.

It also keeps a saturating count of completed recoveries for status readout.

Parameters:
- DRAIN_CYC, 16: consecutive idle (i_busy=0) cycles required before flushing; min 1.
- FLUSH_CYC, 4: cycles o_flush is held high; min 1.
- HOLDOFF_CYC, 8: guard cycles after clear before re-arming; min 1.
- TO_CYC, 1024: maximum total cycles in DRAIN (used only with the optional feature); must exceed DRAIN_CYC.
- CNT_W, 8: width of the recovery counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_stall  in  1  sticky stall flag from the upstream flag register
- i_busy  in  1  datapath activity (FIFO non-empty or frame in flight)
- o_flush  out  1  FIFO/pipeline flush, high for FLUSH_CYC cycles
- o_clr  out  1  single-cycle clear to the sticky flag register
- o_recovering  out  1  high in every state except IDLE
- o_state  out  3  current FSM state encoding
- o_rcv_cnt  out  CNT_W  completed recoveries, saturating
- o_timeout  out  1  sticky drain-timeout indication (tied 0 without the optional feature)

Behaviour:
- Reset: async on i_rst_n low. Values: state=IDLE; all counters 0; o_flush=0, o_clr=0, o_recovering=0, o_rcv_cnt=0, o_timeout=0, o_state=IDLE.
- Moore outputs: o_flush, o_clr, o_recovering and o_state decode only from the state register, so there is no combinational path from i_stall or i_busy to any output.
- States and encoding: IDLE=0, DRAIN=1, FLUSH=2, CLEAR=3, HOLDOFF=4.
- IDLE: at an edge with i_stall=1, go to DRAIN and set drain_cnt=0.
- DRAIN, idle cycle (i_busy=0): drain_cnt increments. At the edge where drain_cnt==DRAIN_CYC-1 and i_busy=0, go to FLUSH. A fully idle drain therefore lasts exactly DRAIN_CYC cycles.
- DRAIN, busy cycle (i_busy=1): drain_cnt resets to 0, so idle cycles must be consecutive.
- DRAIN, i_stall=0 at an edge: the flag was cleared externally. Go to IDLE with no flush and no count increment. This check has priority over the i_busy handling.
- FLUSH: stays exactly FLUSH_CYC cycles, then goes to CLEAR. i_stall and i_busy are ignored.
- CLEAR: lasts one cycle, then goes to HOLDOFF.
  - o_clr=1 for that cycle.
  - o_rcv_cnt increments, saturating at all-ones; no wrap.
- HOLDOFF: stays HOLDOFF_CYC cycles, ignoring i_stall. On exit:
  - i_stall=1 (flag set again): go directly to DRAIN with drain_cnt=0.
  - otherwise: go to IDLE.
- Counter widths: each counter is $clog2 of its maximum+1 bits, minimum 1.
- Reset mid-operation: any state returns to IDLE immediately and o_flush/o_clr drop asynchronously.

Optional Feature:
Macro: STALL_RCV_TIMEOUT_EN.
- Defined:
  - A to_cnt counter runs for the whole time spent in DRAIN and clears on DRAIN entry.
  - If to_cnt reaches TO_CYC-1 while still in DRAIN, the FSM goes to FLUSH regardless of i_busy.
  - o_timeout is set to 1 and stays 1 until reset (sticky).
- Not defined: no to_cnt logic is built, o_timeout is constant 0, and DRAIN can last indefinitely.

Decomposition:
- Shared package / include file stall_rcv_pkg holds:
  - state encodings (IDLE..HOLDOFF, 3 bits);
  - the counter-width helper function.
- No sub-module: a single FSM plus counters is sufficient.
- The shared phase counter may be reused across DRAIN, FLUSH and HOLDOFF.

Test Plan:
Parameters for all scenarios: DRAIN_CYC=4, FLUSH_CYC=2, HOLDOFF_CYC=3, TO_CYC=10.
1. i_stall rises and is sampled at edge 0, i_busy=0 throughout -> DRAIN for cycles 1-4, o_flush=1 for cycles 5-6, o_clr=1 for cycle 7 only, HOLDOFF for cycles 8-10, IDLE at cycle 11; o_rcv_cnt=1.
2. Same stimulus, but i_busy=1 during cycle 3 -> drain restarts; FLUSH is delayed until 4 consecutive idle cycles have occurred after cycle 3.
3. i_stall drops during cycle 2 of DRAIN -> IDLE at the next edge; o_flush and o_clr never assert; o_rcv_cnt unchanged.
4. i_stall stays 1 through the end of HOLDOFF -> DRAIN at cycle 11 with no IDLE cycle; second recovery completes; o_rcv_cnt=2.
5. CNT_W=2, run 5 back-to-back recoveries -> o_rcv_cnt sequence 1,2,3,3,3.
6. STALL_RCV_TIMEOUT_EN defined, i_busy stuck at 1 -> FLUSH after 10 DRAIN cycles and o_timeout=1 until reset. Without the macro, the FSM stays in DRAIN and o_timeout=0.
7. Assert i_rst_n=0 during FLUSH -> o_flush=0 immediately (asynchronous); state=IDLE; o_rcv_cnt=0.

Source files
------------

// File: rtl/stall_rcv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stall_rcv_pkg
// Description : Shared state encodings and counter-width helper for the
//               stall recovery controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stall_rcv_pkg;

    // FSM state encodings (3 bits)
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_drain   = 3'd1;
    localparam logic [2:0] c_st_flush   = 3'd2;
    localparam logic [2:0] c_st_clear   = 3'd3;
    localparam logic [2:0] c_st_holdoff = 3'd4;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_w(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_recovery_ctrl
// Description : Recovers from a sticky stall flag: waits for the datapath to
//               drain, flushes the FIFOs, clears the flag, then holds off
//               re-arming for a guard interval. Counts completed recoveries.
//               Optional drain timeout enabled by macro STALL_RCV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_recovery_ctrl
    import stall_rcv_pkg::*;
#(
    parameter int DRAIN_CYC   = 16,
    parameter int FLUSH_CYC   = 4,
    parameter int HOLDOFF_CYC = 8,
    parameter int TO_CYC      = 1024,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_busy,
    output logic             o_flush,
    output logic             o_clr,
    output logic             o_recovering,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_rcv_cnt,
    output logic             o_timeout
);

    // One phase counter is shared by DRAIN, FLUSH and HOLDOFF, so it is sized
    // for the longest of the three.
    localparam int c_ph_max_a = (DRAIN_CYC > FLUSH_CYC) ? DRAIN_CYC : FLUSH_CYC;
    localparam int c_ph_max   = (c_ph_max_a > HOLDOFF_CYC) ? c_ph_max_a : HOLDOFF_CYC;
    localparam int c_ph_w     = cnt_w(c_ph_max - 1);

    localparam logic [c_ph_w-1:0] c_drain_last = c_ph_w'(DRAIN_CYC - 1);
    localparam logic [c_ph_w-1:0] c_flush_last = c_ph_w'(FLUSH_CYC - 1);
    localparam logic [c_ph_w-1:0] c_hold_last  = c_ph_w'(HOLDOFF_CYC - 1);

    // Elaboration-time parameter sanity
    if (DRAIN_CYC < 1 || FLUSH_CYC < 1 || HOLDOFF_CYC < 1 || TO_CYC <= DRAIN_CYC
        || CNT_W < 1) begin : g_param_check
        $error("stall_recovery_ctrl: illegal parameter combination");
    end

    logic [2:0]        r_state;
    logic [c_ph_w-1:0] r_phase;
    logic [CNT_W-1:0]  r_rcv_cnt;
    logic              w_to_hit;

`ifdef STALL_RCV_TIMEOUT_EN
    localparam int                c_to_w    = cnt_w(TO_CYC - 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TO_CYC - 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout;

    assign w_to_hit = (r_to_cnt == c_to_last);

    // Total time spent in DRAIN; held at zero elsewhere so every entry starts fresh
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == c_st_drain) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sticky timeout flag, set when a drain is abandoned for taking too long
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout <= 1'b0;
        end else if (r_state == c_st_drain && i_stall && w_to_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Recovery FSM and shared phase counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
            r_phase <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_phase <= '0;
                    if (i_stall) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // External clear of the flag wins over everything else
                    if (!i_stall) begin
                        r_state <= c_st_idle;
                        r_phase <= '0;
                    end else if (w_to_hit) begin
                        r_state <= c_st_flush;
                        r_phase <= '0;
                    end else if (i_busy) begin
                        r_phase <= '0;
                    end else if (r_phase == c_drain_last) begin
                        r_state <= c_st_flush;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                c_st_flush: begin
                    if (r_phase == c_flush_last) begin
                        r_state <= c_st_clear;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                c_st_clear: begin
                    r_state <= c_st_holdoff;
                    r_phase <= '0;
                end
                c_st_holdoff: begin
                    if (r_phase == c_hold_last) begin
                        r_state <= i_stall ? c_st_drain : c_st_idle;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Saturating count of completed recoveries, bumped on the CLEAR cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcv_cnt <= '0;
        end else if (r_state == c_st_clear && r_rcv_cnt != {CNT_W{1'b1}}) begin
            r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
        end
    end

    assign o_flush      = (r_state == c_st_flush);
    assign o_clr        = (r_state == c_st_clear);
    assign o_recovering = (r_state != c_st_idle);
    assign o_state      = r_state;
    assign o_rcv_cnt    = r_rcv_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stall_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_recovery_ctrl
// Description : Self-checking bench for stall_recovery_ctrl (vector tables
//               plus hand sequences for saturation and async reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_recovery_ctrl;
    import stall_rcv_pkg::*;

    localparam int DRAIN_CYC   = 4;
    localparam int FLUSH_CYC   = 2;
    localparam int HOLDOFF_CYC = 3;
    localparam int TO_CYC      = 10;
    localparam int CNT_W       = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             busy;
    logic             flush;
    logic             clr;
    logic             recovering;
    logic [2:0]       state;
    logic [CNT_W-1:0] rcv_cnt;
    logic             timeout;

    always #5 clk = ~clk;

    stall_recovery_ctrl #(
        .DRAIN_CYC   (DRAIN_CYC),
        .FLUSH_CYC   (FLUSH_CYC),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .TO_CYC      (TO_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_busy       (busy),
        .o_flush      (flush),
        .o_clr        (clr),
        .o_recovering (recovering),
        .o_state      (state),
        .o_rcv_cnt    (rcv_cnt),
        .o_timeout    (timeout)
    );

    typedef struct {
        logic             stall;
        logic             busy;
        logic [2:0]       st;
        logic [CNT_W-1:0] rcv;
        logic             tmo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic s, input logic b, input logic [2:0] st,
                                input int rcv, input logic t);
        vec_t v;
        v.stall = s;
        v.busy  = b;
        v.st    = st;
        v.rcv   = CNT_W'(rcv);
        v.tmo   = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t e, input string tag);
        check({tag, " state"},      32'(state),      32'(e.st));
        check({tag, " flush"},      32'(flush),      32'(e.st == c_st_flush));
        check({tag, " clr"},        32'(clr),        32'(e.st == c_st_clear));
        check({tag, " recovering"}, 32'(recovering), 32'(e.st != c_st_idle));
        check({tag, " rcv_cnt"},    32'(rcv_cnt),    32'(e.rcv));
        check({tag, " timeout"},    32'(timeout),    32'(e.tmo));
    endtask

    // Drive each row before an edge, compare the result just after it
    task automatic run_vectors(input string tag);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            stall = vecs[i].stall;
            busy  = vecs[i].busy;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs(e, $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    task automatic do_reset(input string tag);
        vec_t e;
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        busy  = 1'b0;
        #2;
        e.stall = 1'b0; e.busy = 1'b0; e.st = c_st_idle; e.rcv = '0; e.tmo = 1'b0;
        check_outputs(e, tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bounded wait for a given state, sampled just after each edge
    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (state == st) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out waiting for state %0d, got %0d", tag, st, state);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        busy  = 1'b0;
        #12;
        do_reset("reset0");

        // 1: clean recovery, idle datapath
        for (int i = 0; i < 4; i++) add(1, 0, c_st_drain, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_clear, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, c_st_holdoff, 1, 0);
        add(0, 0, c_st_idle, 1, 0);
        add(0, 0, c_st_idle, 1, 0);
        run_vectors("t1");

        // 2: busy cycle restarts the drain
        do_reset("reset2");
        for (int i = 0; i < 3; i++) add(1, 0, c_st_drain, 0, 0);
        add(1, 1, c_st_drain, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, c_st_drain, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_clear, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, c_st_holdoff, 1, 0);
        add(0, 0, c_st_idle, 1, 0);
        run_vectors("t2");

        // 3: flag cleared externally mid-drain (busy high too: stall check wins)
        do_reset("reset3");
        add(1, 0, c_st_drain, 0, 0);
        add(1, 0, c_st_drain, 0, 0);
        add(0, 1, c_st_idle, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 0, c_st_idle, 0, 0);
        run_vectors("t3");

        // 4: flag set again through HOLDOFF, straight back to DRAIN
        do_reset("reset4");
        for (int i = 0; i < 4; i++) add(1, 0, c_st_drain, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_flush, 0, 0);
        add(1, 0, c_st_clear, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, c_st_holdoff, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 0, c_st_drain, 1, 0);
        add(1, 0, c_st_flush, 1, 0);
        add(1, 0, c_st_flush, 1, 0);
        add(1, 0, c_st_clear, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, c_st_holdoff, 2, 0);
        add(0, 0, c_st_idle, 2, 0);
        run_vectors("t4");

        // 5: back-to-back recoveries saturate a 2-bit counter
        do_reset("reset5");
        @(negedge clk);
        stall = 1'b1;
        busy  = 1'b0;
        for (int r = 0; r < 5; r++) begin
            wait_state(c_st_clear, 40, $sformatf("t5 wait clear %0d", r));
            @(posedge clk);
            #1;
            check($sformatf("t5 rcv_cnt after recovery %0d", r + 1), 32'(rcv_cnt),
                  (r + 1 > 3) ? 32'd3 : 32'(r + 1));
        end

        // 6: datapath stuck busy
        do_reset("reset6");
`ifdef STALL_RCV_TIMEOUT_EN
        for (int i = 0; i < 10; i++) add(1, 1, c_st_drain, 0, 0);
        add(1, 1, c_st_flush, 0, 1);
        add(0, 1, c_st_flush, 0, 1);
        add(0, 1, c_st_clear, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, c_st_holdoff, 1, 1);
        add(0, 1, c_st_idle, 1, 1);
        add(0, 0, c_st_idle, 1, 1);
`else
        for (int i = 0; i < 16; i++) add(1, 1, c_st_drain, 0, 0);
`endif
        run_vectors("t6");

        // 7: asynchronous reset during FLUSH of a second recovery
        do_reset("reset7");
        @(negedge clk);
        stall = 1'b1;
        busy  = 1'b0;
        wait_state(c_st_holdoff, 40, "t7 wait holdoff");
        wait_state(c_st_flush, 40, "t7 wait flush");
        check("t7 flush before reset", 32'(flush), 32'd1);
        check("t7 rcv_cnt before reset", 32'(rcv_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7 flush async drop", 32'(flush), 32'd0);
        check("t7 clr async", 32'(clr), 32'd0);
        check("t7 state async", 32'(state), 32'(c_st_idle));
        check("t7 recovering async", 32'(recovering), 32'd0);
        check("t7 rcv_cnt async", 32'(rcv_cnt), 32'd0);
        check("t7 timeout async", 32'(timeout), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t7 state after release", 32'(state), 32'(c_st_idle));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
